// File: rtl/cpu_step_ctrl.sv
//============================================================================
// Module   : cpu_step_ctrl
// Purpose  : CPU clock-enable generator for the SOPC board build. It debounces
//            the step/burst buttons and provides single-step, N-step burst,
//            divided free-run and full-speed free-run modes. It also exports
//            a step counter and a busy flag for debug display.
// Options  : `define STEP_BREAK_EN adds a PC breakpoint (pc_i, brk_addr,
//            brk_hit).
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module cpu_step_ctrl #(
    parameter logic [19:0] DEB_MAX  = 20'd1_000_000,
    parameter int          DIV_BITS = 24
) (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        btn_step,
    input  logic        btn_burst,
    input  logic [1:0]  mode,
    input  logic [7:0]  burst_len,
`ifdef STEP_BREAK_EN
    input  logic [31:0] pc_i,
    input  logic [31:0] brk_addr,
    output logic        brk_hit,
`endif
    output logic        cpu_ce,
    output logic        busy,
    output logic [15:0] step_count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_STEP  = 2'd1;
    localparam logic [1:0] c_ST_BURST = 2'd2;
    localparam logic [1:0] c_ST_RUN   = 2'd3;

    logic [1:0]          w_btn_raw;
    logic [1:0]          w_press;      // [0] = step press, [1] = burst press
    logic [1:0]          r_mode_s1;
    logic [1:0]          r_mode_s2;
    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [8:0]          r_rem;
    logic [8:0]          w_rem_nxt;
    logic [DIV_BITS-1:0] r_div;
    logic                w_div_wrap;
    logic                w_ce_want;
    logic                w_ce_nxt;
    logic                w_run_block;
    logic                w_brk_set;
    logic                r_cpu_ce;
    logic                r_busy;
    logic [15:0]         r_step_count;

    assign w_btn_raw  = {btn_burst, btn_step};
    assign w_div_wrap = &r_div;

    // Per-button synchroniser, debounce counter and press-pulse generator
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic        r_s1;
        logic        r_s2;
        logic        r_stable;
        logic        r_press;
        logic [19:0] r_cnt;

        // Stable level follows the synced level only after DEB_MAX agreeing cycles
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_stable <= 1'b0;
                r_press  <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_s1    <= w_btn_raw[gi];
                r_s2    <= r_s1;
                r_press <= 1'b0;
                if (r_s2 != r_stable) begin
                    if (r_cnt == DEB_MAX - 20'd1) begin
                        r_stable <= r_s2;
                        r_cnt    <= '0;
                        r_press  <= r_s2;   // pulse only on a rising stable edge
                    end else begin
                        r_cnt <= r_cnt + 20'd1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    // Two-stage synchroniser for the mode switches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode_s1 <= 2'b00;
            r_mode_s2 <= 2'b00;
        end else begin
            r_mode_s1 <= mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

`ifdef STEP_BREAK_EN
    logic r_brk_hit;
    // A pending breakpoint holds the controller in IDLE until the next press
    assign w_run_block = r_brk_hit;
`else
    assign w_run_block = 1'b0;
`endif

    // Next-state and enable decode; cpu_ce is registered from w_ce_nxt
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_ce_want   = 1'b0;
        w_ce_nxt    = 1'b0;
        w_brk_set   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_mode_s2 == 2'b00 && w_press[0]) begin
                    w_state_nxt = c_ST_STEP;
                    w_ce_nxt    = 1'b1;     // enable is high while in STEP
                end else if (r_mode_s2 == 2'b01 && w_press[1]) begin
                    w_state_nxt = c_ST_BURST;
                    w_rem_nxt   = (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
                end else if (r_mode_s2[1] && !w_run_block) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_STEP: begin
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_BURST: begin
                if (r_mode_s2 != 2'b01) begin
                    w_state_nxt = c_ST_IDLE;   // abort takes priority over a wrap
                end else if (w_div_wrap) begin
                    w_ce_want = 1'b1;
                    w_rem_nxt = r_rem - 9'd1;
                    if (r_rem == 9'd1) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_RUN: begin
                if (!r_mode_s2[1]) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_ce_want = r_mode_s2[0] | w_div_wrap;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
`ifdef STEP_BREAK_EN
        if (w_ce_want && (pc_i == brk_addr)) begin
            w_ce_want   = 1'b0;
            w_brk_set   = 1'b1;
            w_state_nxt = c_ST_IDLE;
        end
`endif
        w_ce_nxt = w_ce_nxt | w_ce_want;
    end

    // State, burst counter, divider and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_IDLE;
            r_rem        <= '0;
            r_div        <= '0;
            r_cpu_ce     <= 1'b0;
            r_busy       <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rem    <= w_rem_nxt;
            r_cpu_ce <= w_ce_nxt;
            r_busy   <= (w_state_nxt == c_ST_BURST) || (w_state_nxt == c_ST_RUN);
            // Divider restarts from zero on every entry into BURST or RUN
            if ((r_state == c_ST_BURST || r_state == c_ST_RUN) && (w_state_nxt == r_state)) begin
                r_div <= r_div + 1'b1;
            end else begin
                r_div <= '0;
            end
            if (w_ce_nxt) begin
                r_step_count <= r_step_count + 16'd1;
            end
        end
    end

`ifdef STEP_BREAK_EN
    // Sticky breakpoint flag, cleared by any accepted button press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_brk_hit <= 1'b0;
        end else if (w_brk_set) begin
            r_brk_hit <= 1'b1;
        end else if (|w_press) begin
            r_brk_hit <= 1'b0;
        end
    end

    assign brk_hit = r_brk_hit;
`endif

    assign cpu_ce     = r_cpu_ce;
    assign busy       = r_busy;
    assign step_count = r_step_count;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
//============================================================================
// Module   : tb_cpu_step_ctrl
// Purpose  : Scoreboard bench for cpu_step_ctrl. Stimulus pushes the expected
//            cycle and step count of every cpu_ce pulse; a monitor pops and
//            compares each pulse the DUT produces.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step;
    logic        btn_burst;
    logic [1:0]  mode;
    logic [7:0]  burst_len;
    logic        cpu_ce;
    logic        busy;
    logic [15:0] step_count;
`ifdef STEP_BREAK_EN
    logic [31:0] pc_i;
    logic [31:0] brk_addr;
    logic        brk_hit;
    logic        pc_en;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_cnt = 16'd0;

    cpu_step_ctrl #(
        .DEB_MAX  (20'd4),
        .DIV_BITS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_burst  (btn_burst),
        .mode       (mode),
        .burst_len  (burst_len),
`ifdef STEP_BREAK_EN
        .pc_i       (pc_i),
        .brk_addr   (brk_addr),
        .brk_hit    (brk_hit),
`endif
        .cpu_ce     (cpu_ce),
        .busy       (busy),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef STEP_BREAK_EN
    // Simple PC model: advances one instruction per enable
    always @(posedge clk) begin
        #1;
        if (pc_en && cpu_ce) pc_i = pc_i + 32'd4;
    end
`endif

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int at_cyc);
        exp_t e;
        exp_cnt = exp_cnt + 16'd1;
        e.cyc = at_cyc;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    // Monitor: every enable pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst === 1'b1 && cpu_ce === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_pulse: cycle %0d count %0h, expected no pulse", cyc, step_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (step_count === e.cnt && cyc >= e.cyc - 1 && cyc <= e.cyc + 1) n_pass++;
                else $display("FAIL pulse: cycle %0d count %0h, expected cycle %0d count %0h",
                              cyc, step_count, e.cyc, e.cnt);
            end
        end
    end

    initial begin
        int c;
        rst = 1'b0; btn_step = 1'b0; btn_burst = 1'b0; mode = 2'b00; burst_len = 8'd0;
`ifdef STEP_BREAK_EN
        pc_i = 32'h100; brk_addr = 32'h10; pc_en = 1'b0;
`endif
        // Reset
        tick(5);
        check("rst_ce", {31'd0, cpu_ce}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_count", {16'd0, step_count}, 32'd0);
        rst = 1'b1;
        tick(5);
        check("idle_ce", {31'd0, cpu_ce}, 32'd0);
        check("idle_count", {16'd0, step_count}, 32'd0);

        // Single step, clean press
        c = cyc; btn_step = 1'b1; push(c + 7);
        tick(10); btn_step = 1'b0; tick(20);
        check("step_sb_empty", sb.size(), 32'd0);
        check("step_count1", {16'd0, step_count}, 32'd1);

        // Bouncing press: no pulse, then a stable press gives one
        repeat (6) begin
            btn_step = 1'b1; tick(2);
            btn_step = 1'b0; tick(2);
        end
        check("bounce_count", {16'd0, step_count}, 32'd1);
        c = cyc; btn_step = 1'b1; push(c + 7);
        tick(10); btn_step = 1'b0; tick(20);
        check("bounce_sb_empty", sb.size(), 32'd0);

        // Burst of 3, divider period 4
        mode = 2'b01; burst_len = 8'd3; tick(4);
        c = cyc; btn_burst = 1'b1;
        for (int k = 0; k < 3; k++) push(c + 11 + 4 * k);
        tick(9);
        check("burst_busy", {31'd0, busy}, 32'd1);
        tick(1); btn_burst = 1'b0; tick(20);
        check("burst_busy_off", {31'd0, busy}, 32'd0);
        check("burst_sb_empty", sb.size(), 32'd0);
        check("burst_count", {16'd0, step_count}, 32'd5);

        // burst_len 0 means 256 enables
        burst_len = 8'd0;
        c = cyc; btn_burst = 1'b1;
        for (int k = 0; k < 256; k++) push(c + 11 + 4 * k);
        tick(10); btn_burst = 1'b0; tick(1040);
        check("burst256_sb_empty", sb.size(), 32'd0);
        check("burst256_count", {16'd0, step_count}, 32'd261);
        check("burst256_busy", {31'd0, busy}, 32'd0);

        // Full-speed run: 100 consecutive enables, then stop
        mode = 2'b11; c = cyc;
        for (int k = 4; k <= 103; k++) push(c + k);
        tick(50);
        check("run_busy", {31'd0, busy}, 32'd1);
        tick(51); mode = 2'b00; tick(10);
        check("run_sb_empty", sb.size(), 32'd0);
        check("run_busy_off", {31'd0, busy}, 32'd0);

        // Divided run
        mode = 2'b10; c = cyc;
        push(c + 7); push(c + 11); push(c + 15);
        tick(15); mode = 2'b00; tick(10);
        check("divrun_sb_empty", sb.size(), 32'd0);
        check("divrun_count", {16'd0, step_count}, 32'd364);

        // Burst aborted by a mode change after the second pulse
        mode = 2'b01; burst_len = 8'd10; tick(4);
        c = cyc; btn_burst = 1'b1;
        push(c + 11); push(c + 15);
        tick(10); btn_burst = 1'b0; tick(3);
        mode = 2'b00; tick(30);
        check("abort_sb_empty", sb.size(), 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a burst
        mode = 2'b01; burst_len = 8'd5; tick(4);
        c = cyc; btn_burst = 1'b1; push(c + 11);
        tick(10); btn_burst = 1'b0; tick(3);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_ce", {31'd0, cpu_ce}, 32'd0);
        check("async_rst_count", {16'd0, step_count}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete(); exp_cnt = 16'd0;
        tick(3); rst = 1'b1; mode = 2'b00; tick(20);
        check("post_rst_count", {16'd0, step_count}, 32'd0);

`ifdef STEP_BREAK_EN
        // Breakpoint at 0x10 while free-running
        pc_i = 32'd0; pc_en = 1'b1; mode = 2'b11; c = cyc;
        for (int k = 4; k <= 7; k++) push(c + k);
        tick(20);
        check("brk_hit", {31'd0, brk_hit}, 32'd1);
        check("brk_busy", {31'd0, busy}, 32'd0);
        check("brk_pc", pc_i, 32'h10);
        check("brk_sb_empty", sb.size(), 32'd0);
        mode = 2'b00; tick(5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
